// File: rtl/slow_clk_monitor_pkg.sv
// Shared constants and FSM encoding for the slow-clock monitor.
package slow_clk_monitor_pkg;

  localparam int CLK_SYS_HZ   = 100000000;
  localparam int DEF_EXP_HALF = 45000001;
  localparam int DEF_TOL      = 1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } mon_state_t;

endpackage

// File: rtl/slow_clk_monitor_sync_edge_det.sv
// Multi-flop synchroniser with edge detection on the synchronised level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow-clock receiver: synchronised rise/fall ticks, half-period measurement
// with too-fast / too-slow / lost detection, and a wrapping edge counter.
module slow_clk_monitor
  import slow_clk_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 27,
  parameter int EXP_HALF    = DEF_EXP_HALF,
  parameter int TOL         = DEF_TOL,
  parameter int EDGE_W      = 16
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  input  logic              slow_clk_in,
  output logic              tick_rise,
  output logic              tick_fall,
  output logic [CNT_W-1:0]  half_period,
  output logic              period_valid,
  output logic              too_fast,
  output logic              too_slow,
  output logic              lost,
  output logic [EDGE_W-1:0] edge_count
);

  localparam int LO_I = (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
  localparam logic [CNT_W-1:0] LO  = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(EXP_HALF + TOL + 1);

  if (longint'(EXP_HALF) + longint'(TOL) + 1 > (longint'(1) << CNT_W) - 1) begin : g_width_err
    $error("slow_clk_monitor: EXP_HALF+TOL+1 does not fit in CNT_W bits");
  end

  logic       level, rise, fall, any_edge;
  logic [CNT_W-1:0] cnt, cnt_inc;
  mon_state_t state;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .async_in   (slow_clk_in),
    .level      (level),
    .rise       (rise),
    .fall       (fall)
  );

  assign any_edge = rise | fall;
  assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

  // cnt is reloaded with 1 on the tick cycle so the value captured at the
  // next tick equals the number of cycles between the two ticks.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tick_rise    <= 1'b0;
      tick_fall    <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      too_fast     <= 1'b0;
      too_slow     <= 1'b0;
      lost         <= 1'b0;
      edge_count   <= '0;
    end else begin
      tick_rise    <= any_edge & level;
      tick_fall    <= any_edge & ~level;
      period_valid <= 1'b0;
      if (any_edge) edge_count <= edge_count + 1'b1;
      case (state)
        IDLE: begin
          if (any_edge) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (any_edge) begin
            half_period  <= cnt;
            period_valid <= 1'b1;
            too_fast     <= (cnt < LO);
            too_slow     <= (cnt > HI);
            cnt          <= CNT_W'(1);
          end else if (cnt == LIM) begin
            state    <= LOST;
            lost     <= 1'b1;
            too_slow <= 1'b1;
            cnt      <= cnt_inc;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LOST: begin
          if (any_edge) begin
            state <= MEASURE;
            lost  <= 1'b0;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Randomised and directed bench for slow_clk_monitor against a cycle-time reference model.
module tb_slow_clk_monitor;

  localparam int EXP = 10, TOL = 2, SS = 2, EW = 4, CW = 8;
  localparam int LIM = EXP + TOL + 1;

  logic          clk_100MHz = 1'b0;
  logic          rst_n = 1'b0;
  logic          slow_clk_in = 1'b0;
  logic          tick_rise, tick_fall, period_valid, too_fast, too_slow, lost;
  logic [CW-1:0] half_period;
  logic [EW-1:0] edge_count;

  slow_clk_monitor #(
    .SYNC_STAGES(SS), .CNT_W(CW), .EXP_HALF(EXP), .TOL(TOL), .EDGE_W(EW)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .rst_n        (rst_n),
    .slow_clk_in  (slow_clk_in),
    .tick_rise    (tick_rise),
    .tick_fall    (tick_fall),
    .half_period  (half_period),
    .period_valid (period_valid),
    .too_fast     (too_fast),
    .too_slow     (too_slow),
    .lost         (lost),
    .edge_count   (edge_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_cmp = 0, n_bad = 0;
  int cyc = 8;
  bit v [0:8191];     // input level driven just after each posedge
  bit cur = 1'b0;

  // reference model, expressed in absolute tick times
  bit measuring, m_lost_st;
  int last_tick;
  int m_hp, m_ec;
  bit m_tr, m_tf, m_pv, m_fast, m_slow, m_lost;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    measuring = 0; m_lost_st = 0; last_tick = 0;
    m_hp = 0; m_ec = 0;
    m_tr = 0; m_tf = 0; m_pv = 0; m_fast = 0; m_slow = 0; m_lost = 0;
  endtask

  // The input is seen as a tick three clock edges after it changes.
  task automatic model_edge();
    bit r, f;
    int dt;
    r = v[cyc-3] && !v[cyc-4];
    f = !v[cyc-3] && v[cyc-4];
    m_tr = r; m_tf = f; m_pv = 0;
    dt = cyc - last_tick;
    if (r || f) begin
      m_ec = (m_ec + 1) % (1 << EW);
      if (measuring && !m_lost_st) begin
        m_hp = dt; m_pv = 1;
        m_fast = (dt < EXP - TOL);
        m_slow = (dt > EXP + TOL);
      end
      m_lost_st = 0; m_lost = 0;
      measuring = 1;
      last_tick = cyc;
    end else if (measuring && !m_lost_st && dt == LIM) begin
      m_lost_st = 1; m_lost = 1; m_slow = 1;
    end
  endtask

  task automatic check_all();
    chk("tick_rise", tick_rise, m_tr);
    chk("tick_fall", tick_fall, m_tf);
    chk("overlap", tick_rise & tick_fall, 0);
    chk("period_valid", period_valid, m_pv);
    chk("half_period", half_period, m_hp);
    chk("too_fast", too_fast, m_fast);
    chk("too_slow", too_slow, m_slow);
    chk("lost", lost, m_lost);
    chk("edge_count", edge_count, m_ec);
  endtask

  task automatic step(input bit val);
    @(posedge clk_100MHz);
    cyc++;
    if (!rst_n) begin
      clear_model();
      v[cyc-1] = 0; v[cyc-2] = 0; v[cyc-3] = 0;
    end else begin
      model_edge();
    end
    #1 slow_clk_in = val;
    v[cyc] = val;
    cur = val;
    @(negedge clk_100MHz);
    check_all();
  endtask

  // toggle the input and hold the new level for n cycles in total
  task automatic half(input int n);
    step(~cur);
    repeat (n - 1) step(cur);
  endtask

  // one-cycle asynchronous reset pulse, called at a negedge
  task automatic pulse_reset(input bit val);
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("async_clr_hp", half_period, 0);
    chk("async_clr_flags", {too_fast, too_slow, lost, period_valid, tick_rise, tick_fall}, 0);
    chk("async_clr_ec", edge_count, 0);
    step(val);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_model();
    // 1: toggling under reset, release with input low
    for (int i = 0; i < 8; i++) step(i[0]);
    step(1'b0); step(1'b0); step(1'b0); step(1'b0);
    rst_n = 1'b1;
    repeat (8) step(1'b0);
    // 2: first edge, then square wave of half-period 10
    for (int i = 0; i < 6; i++) half(10);
    // 3: boundary half-periods
    half(8); half(12); half(7); half(10); half(13); half(10); half(10);
    // 4: stall, recovery edge, then a good measurement
    half(20); half(10); half(10);
    // 5: reset mid-measurement with the input high
    step(~cur); repeat (4) step(cur);
    pulse_reset(cur);
    repeat (6) step(cur);
    half(10); half(10); half(10);
    // 6: 17 edges from reset wrap edge_count to 1
    step(1'b0); step(1'b0);
    pulse_reset(1'b0);
    repeat (6) step(1'b0);
    for (int i = 0; i < 17; i++) half(3);
    repeat (5) step(cur);
    chk("edge_wrap", edge_count, 1);
    // random half-periods with occasional resets
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset(cur);
      half($urandom_range(1, 16));
    end
    repeat (20) step(cur);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
